// File: rtl/bp_update_scheduler_if.sv
// Pipeline-facing bundle of the branch predictor update scheduler: E-stage resolutions in,
// redirect/flush and table write port out.
interface bp_update_scheduler_if #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 8,
  parameter int QDEPTH   = 4
);
  logic                      resolve_valid;
  logic [XLEN-1:0]           resolve_pc;
  logic                      resolve_taken;
  logic [XLEN-1:0]           resolve_target;
  logic                      resolve_pred_taken;
  logic [1:0]                resolve_ctr;
  logic                      lookup_active;
  logic                      init_busy;
  logic                      flush_d;
  logic                      flush_e;
  logic                      redirect_valid;
  logic [XLEN-1:0]           redirect_pc;
  logic                      tbl_we;
  logic                      tbl_we_target;
  logic [IDX_BITS-1:0]       tbl_idx;
  logic [1:0]                tbl_ctr_wdata;
  logic [XLEN-1:0]           tbl_target_wdata;
  logic [$clog2(QDEPTH):0]   q_count;
  logic                      overflow;

  modport master (
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
           resolve_pred_taken, resolve_ctr, lookup_active,
    input  init_busy, flush_d, flush_e, redirect_valid, redirect_pc,
           tbl_we, tbl_we_target, tbl_idx, tbl_ctr_wdata, tbl_target_wdata,
           q_count, overflow
  );

  modport slave (
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
           resolve_pred_taken, resolve_ctr, lookup_active,
    output init_busy, flush_d, flush_e, redirect_valid, redirect_pc,
           tbl_we, tbl_we_target, tbl_idx, tbl_ctr_wdata, tbl_target_wdata,
           q_count, overflow
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Write-side owner of the 2-bit branch predictor table: clears it after reset, issues
// mispredict redirects, and drains queued counter/target updates on idle table cycles.
//   state   | meaning
//   ST_INIT | sweeping zeros into every table index, pipeline held
//   ST_RUN  | redirects live, update FIFO drains when lookup is idle
module bp_update_scheduler #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 8,
  parameter int QDEPTH   = 4
) (
  input logic                  clk,
  input logic                  rst,
  bp_update_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [1:0]          ctr;
    logic                taken;
    logic [XLEN-1:0]     target;
  } entry_t;

  logic [0:0]          state_q, state_d;
  logic [IDX_BITS-1:0] sweep_q, sweep_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  entry_t              fifo_q [QDEPTH];
  entry_t              fifo_d [QDEPTH];

  logic   run, init_wr, mispredict, full, push, pop;
  logic [1:0] new_ctr;
  entry_t head;

  always_comb begin
    run        = (state_q == ST_RUN) && !rst;
    init_wr    = (state_q == ST_INIT) && !rst;
    mispredict = run && bus.resolve_valid && (bus.resolve_taken != bus.resolve_pred_taken);
    full       = (count_q == CNT_W'(QDEPTH));
    pop        = run && (count_q != '0) && !bus.lookup_active;
    // A full FIFO still accepts the new entry when the head leaves in the same cycle.
    push       = run && bus.resolve_valid && (!full || pop);
    head       = fifo_q[rd_ptr_q];

    if (bus.resolve_taken)
      new_ctr = (bus.resolve_ctr == 2'b11) ? 2'b11 : bus.resolve_ctr + 2'd1;
    else
      new_ctr = (bus.resolve_ctr == 2'b00) ? 2'b00 : bus.resolve_ctr - 2'd1;

    state_d    = state_q;
    sweep_d    = sweep_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    fifo_d     = fifo_q;

    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + IDX_BITS'(1);
      if (sweep_q == '1)
        state_d = ST_RUN;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = '{idx:    bus.resolve_pc[IDX_BITS+1:2],
                           ctr:    new_ctr,
                           taken:  bus.resolve_taken,
                           target: bus.resolve_target};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (run && bus.resolve_valid && !push)
      overflow_d = 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    bus.init_busy        = rst || (state_q == ST_INIT);
    bus.flush_d          = mispredict;
    bus.flush_e          = mispredict;
    bus.redirect_valid   = mispredict;
    bus.redirect_pc      = '0;
    if (mispredict)
      bus.redirect_pc = bus.resolve_taken ? bus.resolve_target
                                          : bus.resolve_pc + XLEN'(4);

    bus.tbl_we           = 1'b0;
    bus.tbl_we_target    = 1'b0;
    bus.tbl_idx          = '0;
    bus.tbl_ctr_wdata    = 2'b00;
    bus.tbl_target_wdata = '0;
    if (init_wr) begin
      bus.tbl_we        = 1'b1;
      bus.tbl_we_target = 1'b1;
      bus.tbl_idx       = sweep_q;
    end else if (pop) begin
      bus.tbl_we           = 1'b1;
      bus.tbl_we_target    = head.taken;
      bus.tbl_idx          = head.idx;
      bus.tbl_ctr_wdata    = head.ctr;
      bus.tbl_target_wdata = head.target;
    end

    bus.q_count  = rst ? '0 : count_q;
    bus.overflow = rst ? 1'b0 : overflow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset: occupancy and pointers gate every read.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed test-plan steps plus random traffic checked
// against a queue-based model of the update FIFO and redirect rules.
module tb_bp_update_scheduler;
  localparam int XLEN = 32;
  localparam int IDX_BITS = 8;
  localparam int QDEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [7:0]  idx;
    logic [1:0]  ctr;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  ent_t mq[$];
  logic m_ovf = 1'b0;

  logic [31:0] o_rpc, o_tgt;
  logic        o_rv, o_we, o_wet, o_ovf;
  logic [7:0]  o_idx;
  logic [1:0]  o_ctr;
  logic [2:0]  o_qc;

  bp_update_scheduler_if #(.XLEN(XLEN), .IDX_BITS(IDX_BITS), .QDEPTH(QDEPTH)) bus ();

  bp_update_scheduler #(.XLEN(XLEN), .IDX_BITS(IDX_BITS), .QDEPTH(QDEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic pt, input logic [1:0] ctr,
                       input logic la);
    bus.resolve_valid      = v;
    bus.resolve_pc         = pc;
    bus.resolve_taken      = tk;
    bus.resolve_target     = tgt;
    bus.resolve_pred_taken = pt;
    bus.resolve_ctr        = ctr;
    bus.lookup_active      = la;
  endtask

  // One RUN cycle: drive, check combinational outputs against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic pt, input logic [1:0] ctr,
                      input logic la);
    logic        mis, popped, room;
    logic [31:0] exp_pc;
    int          c, pre;
    ent_t        e;
    drive(v, pc, tk, tgt, pt, ctr, la);
    #1;
    mis    = v && (tk != pt);
    exp_pc = mis ? (tk ? tgt : pc + 32'd4) : 32'd0;
    chk("flush_d", bus.flush_d, mis);
    chk("flush_e", bus.flush_e, mis);
    chk("redirect_valid", bus.redirect_valid, mis);
    chk("redirect_pc", bus.redirect_pc, exp_pc);
    pre    = mq.size();
    popped = (pre != 0) && !la;
    chk("tbl_we", bus.tbl_we, popped);
    if (popped) begin
      chk("tbl_idx", bus.tbl_idx, mq[0].idx);
      chk("tbl_ctr_wdata", bus.tbl_ctr_wdata, mq[0].ctr);
      chk("tbl_we_target", bus.tbl_we_target, mq[0].tk);
      if (mq[0].tk) chk("tbl_target_wdata", bus.tbl_target_wdata, mq[0].tgt);
    end else begin
      chk("tbl_we_target", bus.tbl_we_target, 1'b0);
    end
    o_rpc = bus.redirect_pc; o_rv = bus.redirect_valid; o_we = bus.tbl_we;
    o_wet = bus.tbl_we_target; o_idx = bus.tbl_idx; o_ctr = bus.tbl_ctr_wdata;
    o_tgt = bus.tbl_target_wdata;
    if (popped) void'(mq.pop_front());
    if (v) begin
      room = (pre < QDEPTH) || popped;
      if (room) begin
        c = int'(ctr);
        c = tk ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
        e.idx = pc[9:2];
        e.ctr = 2'(c);
        e.tk  = tk;
        e.tgt = tgt;
        mq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    o_qc  = bus.q_count;
    o_ovf = bus.overflow;
    chk("q_count", bus.q_count, mq.size());
    chk("overflow", bus.overflow, m_ovf);
    chk("init_busy_run", bus.init_busy, 1'b0);
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 256; i++) begin
      drive(1'($urandom), $urandom, 1'b1, $urandom, 1'b0, 2'($urandom), 1'b1);
      #1;
      chk({tag, "_we"}, {bus.tbl_we, bus.tbl_we_target}, 2'b11);
      chk({tag, "_idx"}, bus.tbl_idx, i);
      chk({tag, "_wdata"}, {bus.tbl_ctr_wdata, bus.tbl_target_wdata}, 34'd0);
      chk({tag, "_busy"}, bus.init_busy, 1'b1);
      chk({tag, "_noflush"}, {bus.flush_d, bus.flush_e, bus.redirect_valid}, 3'b000);
      @(posedge clk);
      #1;
    end
    chk({tag, "_busy_fall"}, bus.init_busy, 1'b0);
    chk({tag, "_qc_empty"}, bus.q_count, 0);
  endtask

  initial begin
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.init_busy, 1'b1);
    chk("rst_qc", bus.q_count, 0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_we", bus.tbl_we, 1'b0);
    chk("rst_redirect", bus.redirect_valid, 1'b0);
    rst = 1'b0;
    sweep_check("init");

    step(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 2'b01, 1'b0);
    chk("tp_taken_rpc", o_rpc, 32'h40);
    chk("tp_taken_rv", o_rv, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
    chk("tp_taken_wr", {o_we, o_wet, o_idx, o_ctr, o_tgt}, {1'b1, 1'b1, 8'h40, 2'b10, 32'h40});

    step(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 2'b00, 1'b0);
    chk("tp_nt_rpc", o_rpc, 32'h204);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
    chk("tp_nt_wr", {o_we, o_wet, o_ctr}, {1'b1, 1'b0, 2'b00});

    step(1'b1, 32'h1FC, 1'b1, 32'h80, 1'b1, 2'b11, 1'b0);
    chk("tp_sat_rv", {o_rv, o_rpc}, 33'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
    chk("tp_sat_wr", {o_we, o_idx, o_ctr}, {1'b1, 8'h7F, 2'b11});

    for (int k = 0; k < 5; k++)
      step(1'b1, 32'h10 + 32'(4 * k), 1'b1, 32'h1000 + 32'(k), 1'b0, 2'b01, 1'b1);
    chk("tp_bp_qc", o_qc, 3'd4);
    chk("tp_bp_ovf", o_ovf, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
      chk("tp_bp_order", {o_we, o_idx, o_tgt}, {1'b1, 8'(4 + k), 32'h1000 + 32'(k)});
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
    chk("tp_bp_lost", o_we, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(($urandom_range(0, 2) != 0), pc, 1'($urandom), $urandom, 1'($urandom),
           2'($urandom), ($urandom_range(0, 2) == 0));
    end

    for (int k = 0; k < 8; k++)
      if (mq.size() != 0) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h300 + 32'(4 * k), 1'b1, 32'h2000, 1'b0, 2'b10, 1'b1);
    chk("mid_qc3", o_qc, 3'd3);
    rst = 1'b1;
    drive(1'b1, 32'h400, 1'b1, 32'h80, 1'b0, 2'b00, 1'b0);
    #1;
    chk("mid_rst_we", bus.tbl_we, 1'b0);
    chk("mid_rst_redirect", bus.redirect_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    chk("mid_qc0", bus.q_count, 0);
    chk("mid_ovf0", bus.overflow, 1'b0);
    sweep_check("reinit");
    for (int k = 0; k < 3; k++)
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Controller that owns the write side of the 256-entry 2-bit branch predictor table (counter + target arrays).
- After reset it clears the table with an INIT sweep and holds the pipeline while it runs.
- In RUN it turns E-stage branch resolutions into same-cycle mispredict redirects and flushes.
- It buffers the counter/target updates in a small FIFO and drains them into the table only on cycles when the D-stage lookup is not using the table.

Parameters:
- XLEN, 32, PC and target width.
- IDX_BITS, 8, table index width; index = pc[IDX_BITS+1:2].
- QDEPTH, 4, update FIFO depth; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- resolve_valid  input  1  a conditional branch is resolved in E this cycle.
- resolve_pc  input  XLEN  PC of the resolving branch (PCE).
- resolve_taken  input  1  actual outcome.
- resolve_target  input  XLEN  computed taken target (PCTargetE).
- resolve_pred_taken  input  1  prediction made for this branch in D, carried to E.
- resolve_ctr  input  2  counter value read for this branch in D, carried to E.
- lookup_active  input  1  D stage is reading the table this cycle; the table write port is blocked.
- init_busy  output  1  INIT sweep in progress; the pipeline must stall.
- flush_d  output  1  flush the D-stage register.
- flush_e  output  1  flush the E-stage register.
- redirect_valid  output  1  fetch must load redirect_pc.
- redirect_pc  output  XLEN  corrected fetch PC.
- tbl_we  output  1  write enable for the counter array.
- tbl_we_target  output  1  write enable for the target array.
- tbl_idx  output  IDX_BITS  write index.
- tbl_ctr_wdata  output  2  counter write data.
- tbl_target_wdata  output  XLEN  target write data.
- q_count  output  $clog2(QDEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky flag: at least one update was dropped.

Behaviour:
- Reset: while rst=1 the block is in INIT with sweep=0, FIFO empty, q_count=0, overflow=0 and init_busy=1. All other outputs are 0.
- rst=1 in any cycle, including mid-sweep or mid-drain, returns the block to this state on the next edge. Queued updates are discarded.

INIT:
- On the first cycle with rst=0, tbl_we=tbl_we_target=1, tbl_idx=sweep, tbl_ctr_wdata=0, tbl_target_wdata=0.
- sweep increments each cycle. The sweep ignores lookup_active and resolve_valid.
- After the write of index 2^IDX_BITS-1 (256 write cycles), the next state is RUN.
- init_busy is 1 through the last write cycle and 0 from the first RUN cycle.
- flush_d, flush_e and redirect_valid are 0 throughout INIT.

RUN, redirect path (combinational, same cycle as resolve_valid):
- mispredict = resolve_valid & (resolve_taken != resolve_pred_taken).
- flush_d = flush_e = redirect_valid = mispredict.
- redirect_pc = resolve_taken ? resolve_target : resolve_pc+4, modulo 2^XLEN. If mispredict=0, redirect_pc=0.
- A redirect is issued even when the update is dropped.

RUN, update generation:
- new_ctr is a saturating 2-bit counter: taken increments and saturates at 11; not-taken decrements and saturates at 00.
- Each resolve_valid pushes {idx, new_ctr, resolve_taken, resolve_target} into the FIFO.

RUN, drain:
- pop = (q_count != 0) & ~lookup_active.
- On pop: tbl_we=1, tbl_idx/tbl_ctr_wdata from the head entry. tbl_we_target = head.taken, with tbl_target_wdata = head.target.
- Table outputs are driven combinationally from the registered head. An entry pushed in cycle N is written no earlier than cycle N+1 (minimum latency 1).
- If pop=0, all write enables are 0.

FIFO boundaries:
- Push and pop in the same cycle while full: both occur and q_count is unchanged.
- Push while full with no pop: the entry is dropped, q_count is unchanged and overflow is set. overflow clears only on rst.
- Pop while empty: not possible by construction.
- Pointers wrap modulo QDEPTH. The FIFO preserves order.
- Duplicate indices are not merged; later entries overwrite earlier ones in order.

Test Plan:
- INIT sweep: rst high 2 cycles, then low. Required: 256 consecutive cycles with tbl_we=1 and tbl_idx 0..255 with wdata 0; init_busy falls on cycle 257; lookup_active=1 during the sweep has no effect.
- Mispredict taken: resolve_pc=0x100, resolve_target=0x40, taken=1, pred=0, ctr=01. Required same cycle: flush_d=flush_e=redirect_valid=1, redirect_pc=0x40. Next cycle: tbl_idx=0x40, tbl_ctr_wdata=10, tbl_we_target=1, tbl_target_wdata=0x40.
- Mispredict not-taken: pc=0x200, taken=0, pred=1, ctr=00. Required: redirect_pc=0x204; later write has tbl_ctr_wdata=00 (saturated) and tbl_we_target=0.
- Correct prediction, saturated counter: pc=0x1FC, taken=1, pred=1, ctr=11. Required: no flush, no redirect; write has tbl_ctr_wdata=11.
- Back-pressure and overflow: lookup_active=1 held while 5 resolves are pushed. Required: q_count reaches 4, overflow=1, the 5th entry is lost. Then drop lookup_active: 4 writes in FIFO order in consecutive cycles.
- Reset mid-drain: 3 entries queued, then rst pulse. Required: q_count=0, overflow=0, INIT sweep restarts at index 0, and no queued entry is written.
